slow_peripheral_bridge_arbiter: RTL and testbench
=================================================

Name: slow_peripheral_bridge_arbiter

Overview:
Round-robin arbiter that lets NUM_MASTERS Avalon-MM masters share the single slave port (s1) of the slow peripheral bridge.
Sits on the bridge's slave_clk side, between the CPU/DMA masters and the bridge.
Grants one transfer per arbitration and forwards it downstream.
Tracks outstanding pipelined reads in an ID FIFO, so each readdatavalid beat returns to the master that issued the read.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
ADDR_W, 7, word address width (matches bridge slave_address)
DATA_W, 32, data width
MAX_PENDING, 8, outstanding-read capacity (power of 2)

Ports:
clk  in  1  single clock (the bridge slave_clk)
reset_n  in  1  synchronous, active-low reset
m_address  in  NUM_MASTERS*ADDR_W  per-master word address, master i at slice i
m_byteenable  in  NUM_MASTERS*4  per-master byteenable
m_writedata  in  NUM_MASTERS*DATA_W  per-master writedata
m_read  in  NUM_MASTERS  per-master read request
m_write  in  NUM_MASTERS  per-master write request
m_waitrequest  out  NUM_MASTERS  per-master waitrequest
m_readdata  out  DATA_W  broadcast readdata
m_readdatavalid  out  NUM_MASTERS  one-hot readdatavalid
m_endofpacket  out  1  broadcast endofpacket
s_address  out  ADDR_W  to bridge slave_address (and slave_nativeaddress)
s_byteenable  out  4  to bridge
s_writedata  out  DATA_W  to bridge
s_read  out  1  to bridge
s_write  out  1  to bridge
s_waitrequest  in  1  from bridge
s_readdata  in  DATA_W  from bridge
s_readdatavalid  in  1  from bridge
s_endofpacket  in  1  from bridge
rsp_error  out  1  sticky: readdatavalid seen with no pending read

Behaviour:
- Reset values: grant_valid=0, grant_idx=0, rr_ptr=0, ID FIFO empty, rsp_error=0.
- Reset values of outputs: s_read=s_write=0, m_waitrequest all 1, m_readdatavalid=0.
- Reset_n low mid-transfer discards all grants and pending IDs. A response arriving after reset sets rsp_error.
- Request of master i: req[i] = m_read[i] | m_write[i].
- A read is eligible only while the ID FIFO is not full.
- A write is always eligible.
- FSM IDLE:
  - No eligible request: stay in IDLE.
  - Otherwise pick the first eligible index at or after rr_ptr, scanning upward with wrap.
  - Register grant_idx and go to BUSY. Arbitration latency is 1 cycle.
- FSM BUSY:
  - s_* outputs are driven combinationally from master grant_idx.
  - m_waitrequest[grant_idx] = s_waitrequest. All other m_waitrequest bits = 1.
  - Accept condition: (s_read|s_write) & !s_waitrequest.
  - On accept: go to IDLE, set rr_ptr = grant_idx+1 mod NUM_MASTERS.
  - On an accepted read: push grant_idx into the ID FIFO.
  - Exactly one transfer per grant. Back-to-back transfers from one master take 2 cycles minimum each.
- If the granted master drops its request while in BUSY (a protocol violation): return to IDLE without issuing. rr_ptr is unchanged.
- Response routing:
  - s_readdatavalid=1 with FIFO non-empty: m_readdatavalid[head]=1 in the same cycle (combinational), then pop.
  - m_readdata = s_readdata and m_endofpacket = s_endofpacket at all times.
- Push and pop in the same cycle are both performed. Occupancy is unchanged, including when the FIFO is full.
- s_readdatavalid with the FIFO empty: no m_readdatavalid bit is asserted, and rsp_error is set. It clears only on reset.
- FIFO full blocks new read grants only. A read already in BUSY was checked at grant time, and pop-before-push keeps occupancy ≤ MAX_PENDING.
- Pointer and count widths are $clog2(MAX_PENDING)+1. Pointers wrap modulo MAX_PENDING.

Optional Feature:
SPB_ARB_FIXED_PRIO_EN
- Defined: IDLE always picks the lowest eligible index (master 0 highest priority). rr_ptr is not used.
- Undefined: round-robin as above.

Decomposition:
- Package spb_arb_pkg holds:
  - arb_state_e enum {IDLE, BUSY}
  - ID width function clog2_min1(NUM_MASTERS)
  - constant BE_W=4
- One sub-module: spb_arb_id_fifo.
  - Synchronous FIFO, width = ID width, depth MAX_PENDING.
  - Ports: push, pop, din, dout, full, empty.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with m_read=2'b11 -> m_waitrequest=2'b11, s_read=0, rsp_error=0.
- Fairness: m_read=2'b11 held, s_waitrequest=0, s_readdatavalid 2 cycles after each read -> s_read grants alternate 0,1,0,1; readdatavalid returns in the same order, one-hot 01,10,01,10.
- Backpressure: master 1 writes 0xDEADBEEF to address 0x15, s_waitrequest=1 for 5 cycles -> s_write and s_writedata held stable for 6 cycles, then m_waitrequest[1] drops for one cycle and the arbiter returns to IDLE.
- Pending limit: 8 reads accepted with no responses -> master 0's 9th read stays waiting; a write from master 1 is still granted; the first response unblocks the read.
- Stray response: s_readdatavalid=1 with no reads pending -> m_readdatavalid=0 and rsp_error=1, held until reset.
- SPB_ARB_FIXED_PRIO_EN defined, m_read=2'b11 continuous -> master 0 takes every grant and master 1 is starved.

Source files
------------

// File: rtl/spb_arb_pkg.sv
// ----------------------------------------------------------------------------
// spb_arb_pkg : shared types and helpers for the slow peripheral bridge arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int BE_W = 4;

  // Master ID width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spb_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// spb_arb_id_fifo : synchronous FIFO holding master IDs of outstanding reads
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spb_arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == PW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/slow_peripheral_bridge_arbiter.sv
// ----------------------------------------------------------------------------
// slow_peripheral_bridge_arbiter : round-robin Avalon-MM arbiter in front of
// the slow peripheral bridge slave port, with read-response routing.
// Option macro SPB_ARB_FIXED_PRIO_EN selects fixed priority (master 0 first).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slow_peripheral_bridge_arbiter
  import spb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic                          m_endofpacket,
  output logic [ADDR_W-1:0]             s_address,
  output logic [BE_W-1:0]               s_byteenable,
  output logic [DATA_W-1:0]             s_writedata,
  output logic                          s_read,
  output logic                          s_write,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  input  logic                          s_endofpacket,
  output logic                          rsp_error
);

  localparam int ID_W = clog2_min1(NUM_MASTERS);

  arb_state_e               state_q;
  logic [ID_W-1:0]          grant_idx_q;
  logic                     rsp_error_q;
  logic [ID_W-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0]   elig;
  logic                     busy;
  logic                     granted_req;
  logic                     accept;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic [ID_W-1:0]          fifo_dout;

  assign busy        = (state_q == BUSY);
  assign elig        = m_write | (m_read & {NUM_MASTERS{~fifo_full}});
  assign granted_req = m_read[grant_idx_q] | m_write[grant_idx_q];

  assign s_address    = m_address[int'(grant_idx_q)*ADDR_W +: ADDR_W];
  assign s_byteenable = m_byteenable[int'(grant_idx_q)*BE_W +: BE_W];
  assign s_writedata  = m_writedata[int'(grant_idx_q)*DATA_W +: DATA_W];
  assign s_read       = busy & m_read[grant_idx_q];
  assign s_write      = busy & m_write[grant_idx_q];
  assign accept       = (s_read | s_write) & ~s_waitrequest;

  assign m_readdata    = s_readdata;
  assign m_endofpacket = s_endofpacket;
  assign fifo_pop      = s_readdatavalid & ~fifo_empty;
  assign rsp_error     = rsp_error_q;

`ifdef SPB_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (elig[i]) pick_idx = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] next_ptr;

  assign next_ptr = (grant_idx_q == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;

  // Scan downward so the last hit is the first eligible index at or after rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    pick_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      if (elig[idx[ID_W-1:0]]) pick_idx = idx[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= next_ptr;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) begin
            grant_idx_q <= pick_idx;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // A master that withdraws its request loses the grant without issuing.
          if (accept || !granted_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (s_readdatavalid && fifo_empty) rsp_error_q <= 1'b1;
    end
  end

  always_comb begin
    m_waitrequest = '1;
    if (busy) m_waitrequest[grant_idx_q] = s_waitrequest;
  end

  always_comb begin
    m_readdatavalid = '0;
    if (fifo_pop) m_readdatavalid[fifo_dout] = 1'b1;
  end

  spb_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & s_read),
    .pop     (fifo_pop),
    .din     (grant_idx_q),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_slow_peripheral_bridge_arbiter.sv
// ----------------------------------------------------------------------------
// tb_slow_peripheral_bridge_arbiter : directed self-checking bench for the
// slow peripheral bridge arbiter (default build or SPB_ARB_FIXED_PRIO_EN).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_slow_peripheral_bridge_arbiter;

  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*AW-1:0] m_address;
  logic [N*4-1:0]  m_byteenable;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [N-1:0]    m_readdatavalid;
  logic            m_endofpacket;
  logic [AW-1:0]   s_address;
  logic [3:0]      s_byteenable;
  logic [DW-1:0]   s_writedata;
  logic            s_read;
  logic            s_write;
  logic            s_waitrequest;
  logic [DW-1:0]   s_readdata;
  logic            s_readdatavalid;
  logic            s_endofpacket;
  logic            rsp_error;

  always #5 clk = ~clk;

  slow_peripheral_bridge_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_PENDING (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .m_endofpacket   (m_endofpacket),
    .s_address       (s_address),
    .s_byteenable    (s_byteenable),
    .s_writedata     (s_writedata),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .s_endofpacket   (s_endofpacket),
    .rsp_error       (rsp_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_addr [4];
  logic [N-1:0]  exp_rdv  [4];
  logic [AW-1:0] got_addr [4];
  logic [N-1:0]  got_rdv  [4];
  logic [1:0]    pipe;
  logic          acc;
  logic          seen;
  int            ng, nr, na, cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef SPB_ARB_FIXED_PRIO_EN
    exp_addr = '{7'h10, 7'h10, 7'h10, 7'h10};
    exp_rdv  = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_addr = '{7'h10, 7'h20, 7'h10, 7'h20};
    exp_rdv  = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    got_addr        = '{default: '0};
    got_rdv         = '{default: '0};
    reset_n         = 1'b0;
    m_read          = 2'b11;
    m_write         = 2'b00;
    m_address       = {7'h20, 7'h10};
    m_byteenable    = 8'hFF;
    m_writedata     = '0;
    s_waitrequest   = 1'b0;
    s_readdata      = 32'hA5A5_0000;
    s_readdatavalid = 1'b0;
    s_endofpacket   = 1'b1;

    // Reset with both masters requesting
    repeat (3) tick();
    @(negedge clk);
    check("rst_waitreq", m_waitrequest, 2'b11);
    check("rst_s_read", s_read, 1'b0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_rdv", m_readdatavalid, 2'b00);
    tick();
    reset_n = 1'b1;

    // Fairness: responses two cycles after each accepted read
    ng = 0; nr = 0; pipe = 2'b00;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      acc = s_read && !s_waitrequest;
      if (acc && ng < 4) begin got_addr[ng] = s_address; ng++; end
      if (m_readdatavalid != 0 && nr < 4) begin got_rdv[nr] = m_readdatavalid; nr++; end
      pipe = {pipe[0], acc};
      tick();
      if (ng >= 4) m_read = 2'b00;
      s_readdatavalid = pipe[1];
    end
    s_readdatavalid = 1'b0;
    check("fair_grants", ng, 4);
    check("fair_rsps", nr, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair_addr%0d", i), got_addr[i], exp_addr[i]);
      check($sformatf("fair_rdv%0d", i), got_rdv[i], exp_rdv[i]);
    end
    check("readdata_pass", m_readdata, 32'hA5A5_0000);
    check("eop_pass", m_endofpacket, 1'b1);

    // Backpressure on a master 1 write
    tick();
    m_address[13:7]    = 7'h15;
    m_writedata[63:32] = 32'hDEAD_BEEF;
    m_byteenable       = 8'h3F;
    m_write            = 2'b10;
    s_waitrequest      = 1'b1;
    @(negedge clk);
    check("bp_arb_latency", s_write, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      s_waitrequest = (k < 5);
      @(negedge clk);
      check($sformatf("bp_write%0d", k), s_write, 1'b1);
      check($sformatf("bp_data%0d", k), s_writedata, 32'hDEAD_BEEF);
      check($sformatf("bp_addr%0d", k), s_address, 7'h15);
      check($sformatf("bp_wait%0d", k), m_waitrequest, (k < 5) ? 2'b11 : 2'b01);
    end
    check("bp_be", s_byteenable, 4'h3);
    tick();
    m_write       = 2'b00;
    s_waitrequest = 1'b0;
    @(negedge clk);
    check("bp_idle_write", s_write, 1'b0);
    check("bp_idle_wait", m_waitrequest, 2'b11);

    // Pending limit: eight reads from master 0 with no responses
    tick();
    m_read = 2'b01;
    na = 0;
    for (int c = 0; c < 40 && na < 8; c++) begin
      @(negedge clk);
      if (s_read && !s_waitrequest) na++;
      tick();
    end
    check("full_accepts", na, 8);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (s_read) seen = 1'b1;
      tick();
    end
    check("full_blocks_read", seen, 1'b0);
    check("full_m0_wait", m_waitrequest, 2'b11);
    m_write = 2'b10;
    @(negedge clk);
    check("full_write_arb", s_write, 1'b0);
    tick();
    @(negedge clk);
    check("full_write_grant", s_write, 1'b1);
    check("full_write_wait", m_waitrequest, 2'b01);
    tick();
    m_write         = 2'b00;
    s_readdatavalid = 1'b1;
    @(negedge clk);
    check("full_first_rsp", m_readdatavalid, 2'b01);
    tick();
    s_readdatavalid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (s_read && !s_waitrequest && s_address == 7'h10) seen = 1'b1;
      tick();
    end
    check("full_unblocked", seen, 1'b1);
    m_read = 2'b00;

    // Drain the eight outstanding reads
    s_readdatavalid = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_readdatavalid == 2'b01) cnt++;
      tick();
    end
    s_readdatavalid = 1'b0;
    check("drain_count", cnt, 8);
    check("drain_no_err", rsp_error, 1'b0);

    // Stray response with nothing pending
    s_readdatavalid = 1'b1;
    @(negedge clk);
    check("stray_rdv", m_readdatavalid, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("stray_sticky", rsp_error, 1'b1);
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("reset_clears_err", rsp_error, 1'b0);
    check("reset_waitreq", m_waitrequest, 2'b11);

    // Response arriving after reset is a stray one
    tick();
    reset_n         = 1'b1;
    s_readdatavalid = 1'b1;
    @(negedge clk);
    check("post_rst_rdv", m_readdatavalid, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("post_rst_err", rsp_error, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
